// File: rtl/candle_sequencer.sv
// Candle sequencer: holds the lit mask and, on snuff, walks lit candles lowest-first through the extinguisher.
// Enable rises two edges after snuff_start; a candle that never acks keeps enable for TIMEOUT_CYCLES and is then skipped.
module candle_sequencer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int GAP_CYCLES     = 2
) (
  input  logic       sys_clk,
  input  logic       clr_n,
  input  logic       light_req,
  input  logic [2:0] light_pos,
  input  logic       snuff_start,
  input  logic       extinguish,
  output logic [2:0] position,
  output logic       enable,
  output logic [7:0] lit,
  output logic       busy,
  output logic       done,
  output logic       timeout_err
);

  typedef enum logic [2:0] {IDLE, SEEK, WAIT, GAP, FIN} state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
  // SEEK supplies the last low cycle between candles, so GAP itself lasts GAP_CYCLES-1 cycles.
  localparam logic [3:0]  GAP_LAST  = 4'(GAP_CYCLES - 2);

  state_t      state_q, state_d;
  logic [7:0]  lit_q, lit_d, skip_q, skip_d;
  logic [2:0]  pos_q, pos_d;
  logic        en_q, en_d, busy_q, busy_d, done_q, done_d;
  logic        terr_q, terr_d, snuff_q, snuff_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic [3:0]  gcnt_q, gcnt_d;
  logic [7:0]  pending, set_mask, clr_mask;
  logic [2:0]  seek_pos;

  always_comb begin
    pending  = lit_q & ~skip_q;
    seek_pos = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pending[i]) seek_pos = 3'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    pos_d    = pos_q;
    en_d     = en_q;
    terr_d   = terr_q;
    wcnt_d   = wcnt_q;
    gcnt_d   = gcnt_q;
    snuff_d  = snuff_start && (state_q == IDLE);
    busy_d   = (state_q == SEEK) || (state_q == WAIT) || (state_q == GAP);
    done_d   = (state_q == FIN);
    set_mask = light_req ? (8'd1 << light_pos) : 8'd0;
    clr_mask = 8'd0;
    case (state_q)
      IDLE: begin
        en_d = 1'b0;
        if (snuff_q) begin
          terr_d  = 1'b0;
          skip_d  = 8'd0;
          state_d = (lit_q != 8'd0) ? SEEK : FIN;
        end
      end
      SEEK: begin
        if (pending != 8'd0) begin
          pos_d   = seek_pos;
          en_d    = 1'b1;
          wcnt_d  = 16'd0;
          state_d = WAIT;
        end else begin
          state_d = FIN;
        end
      end
      WAIT: begin
        wcnt_d = wcnt_q + 16'd1;
        // An ack on the final timeout cycle still counts as a success.
        if (extinguish || (wcnt_q == WAIT_LAST)) begin
          if (extinguish) begin
            clr_mask = 8'd1 << pos_q;
          end else begin
            terr_d = 1'b1;
            skip_d = skip_q | (8'd1 << pos_q);
          end
          en_d    = 1'b0;
          gcnt_d  = 4'd0;
          state_d = (GAP_CYCLES > 1) ? GAP : SEEK;
        end
      end
      GAP: begin
        if (gcnt_q == GAP_LAST) state_d = SEEK;
        else                    gcnt_d  = gcnt_q + 4'd1;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A light request on the bit being extinguished wins.
    lit_d = (lit_q & ~clr_mask) | set_mask;
  end

  always_ff @(posedge sys_clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      lit_q   <= 8'd0;
      skip_q  <= 8'd0;
      pos_q   <= 3'd0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      terr_q  <= 1'b0;
      snuff_q <= 1'b0;
      wcnt_q  <= 16'd0;
      gcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      lit_q   <= lit_d;
      skip_q  <= skip_d;
      pos_q   <= pos_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      terr_q  <= terr_d;
      snuff_q <= snuff_d;
      wcnt_q  <= wcnt_d;
      gcnt_q  <= gcnt_d;
    end
  end

  assign position    = pos_q;
  assign enable      = en_q;
  assign lit         = lit_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_candle_sequencer.sv
// Bench for candle_sequencer: the bench plays extinguisher and predicts service order, window
// lengths, gaps, lit mask and error flag from a mask-level model of the snuff pass.
module tb_candle_sequencer;

  localparam int TIMEOUT = 64;
  localparam int GAP     = 2;

  logic       sys_clk = 1'b0;
  logic       clr_n;
  logic       light_req;
  logic [2:0] light_pos;
  logic       snuff_start;
  logic       extinguish;
  logic [2:0] position;
  logic       enable;
  logic [7:0] lit;
  logic       busy;
  logic       done;
  logic       timeout_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] m_lit;
  logic [7:0] m_skip;
  logic       m_terr;

  candle_sequencer #(.TIMEOUT_CYCLES(TIMEOUT), .GAP_CYCLES(GAP)) dut (
    .sys_clk(sys_clk), .clr_n(clr_n), .light_req(light_req), .light_pos(light_pos),
    .snuff_start(snuff_start), .extinguish(extinguish), .position(position),
    .enable(enable), .lit(lit), .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic int lowest(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) return i;
    return -1;
  endfunction

  task automatic light(input int pos);
    light_req = 1'b1;
    light_pos = 3'(pos);
    tick();
    light_req = 1'b0;
    m_lit = m_lit | (8'd1 << pos);
    check("light", int'(lit), int'(m_lit));
  endtask

  // fixed_d < 0 picks a random ack delay per candle; never marks candles the extinguisher ignores.
  // h1 lights h1_pos on the first enable cycle of h1_cand; h2 lights h2_pos on h2_cand's ack cycle.
  task automatic do_pass(input int fixed_d, input logic [7:0] never, input int h1_cand,
                         input int h1_pos, input int h2_cand, input int h2_pos, input bit gap_ext);
    int n, len, d, exp_len, exp_pos, nserv;
    bit h1_fired, h2_fired, busy_seen, en_seen;
    logic [7:0] set_m, bitm;
    h1_fired = 1'b0;
    h2_fired = 1'b0;
    snuff_start = 1'b1;
    tick();
    snuff_start = 1'b0;
    m_terr = 1'b0;
    m_skip = 8'd0;
    n = 0;
    if (m_lit == 8'd0) begin
      busy_seen = 1'b0;
      en_seen   = 1'b0;
      while (done !== 1'b1 && n < 10) begin
        busy_seen |= busy;
        en_seen   |= enable;
        tick();
        n++;
      end
      check("empty_done_lat", n, 2);
      check("empty_busy", int'(busy_seen | busy), 0);
      check("empty_en", int'(en_seen | enable), 0);
      tick();
      check("empty_done_width", int'(done), 0);
      return;
    end
    while (enable !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check("first_en_lat", n, 2);
    nserv = 0;
    while ((m_lit & ~m_skip) != 8'd0 && nserv < 24) begin
      exp_pos = lowest(m_lit & ~m_skip);
      check("pos", int'(position), exp_pos);
      check("busy_in_pass", int'(busy), 1);
      check("lit_hold", int'(lit), int'(m_lit));
      d = (fixed_d >= 0) ? fixed_d : int'($urandom_range(0, 4));
      if (never[exp_pos]) d = 100000;
      exp_len = (d < TIMEOUT) ? d + 1 : TIMEOUT;
      set_m = 8'd0;
      len = 0;
      while (enable === 1'b1 && len < TIMEOUT + 4) begin
        extinguish = (len == d);
        if (!h1_fired && exp_pos == h1_cand && len == 0) begin
          light_req = 1'b1;
          light_pos = 3'(h1_pos);
          set_m |= 8'd1 << h1_pos;
          h1_fired = 1'b1;
        end else if (!h2_fired && exp_pos == h2_cand && len == d) begin
          light_req = 1'b1;
          light_pos = 3'(h2_pos);
          set_m |= 8'd1 << h2_pos;
          h2_fired = 1'b1;
        end
        tick();
        extinguish = 1'b0;
        light_req  = 1'b0;
        len++;
      end
      check("win_len", len, exp_len);
      bitm = 8'd1 << exp_pos;
      if (d < TIMEOUT) begin
        m_lit = (m_lit & ~bitm) | set_m;
      end else begin
        m_lit  = m_lit | set_m;
        m_skip = m_skip | bitm;
        m_terr = 1'b1;
      end
      check("lit_after", int'(lit), int'(m_lit));
      check("terr", int'(timeout_err), int'(m_terr));
      n = 0;
      if ((m_lit & ~m_skip) != 8'd0) begin
        while (enable !== 1'b1 && n < GAP + 6) begin
          extinguish = gap_ext;
          tick();
          extinguish = 1'b0;
          n++;
        end
        check("gap_len", n, GAP);
      end
      nserv++;
    end
    while (done !== 1'b1 && n < GAP + 6) begin
      extinguish = gap_ext;
      tick();
      extinguish = 1'b0;
      n++;
    end
    check("done_lat", n, GAP + 1);
    check("busy_at_done", int'(busy), 0);
    check("en_at_done", int'(enable), 0);
    check("lit_at_done", int'(lit), int'(m_lit));
    tick();
    check("done_width", int'(done), 0);
  endtask

  initial begin
    int seen;
    logic [7:0] never;
    clr_n       = 1'b0;
    light_req   = 1'b0;
    light_pos   = 3'd0;
    snuff_start = 1'b0;
    extinguish  = 1'b0;
    m_lit  = 8'd0;
    m_skip = 8'd0;
    m_terr = 1'b0;
    #12;
    check("rst_lit", int'(lit), 0);
    check("rst_en", int'(enable), 0);
    check("rst_pos", int'(position), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_terr", int'(timeout_err), 0);
    clr_n = 1'b1;
    tick();

    // Candles 1, 4, 6 acked three cycles into each window.
    light(1); light(4); light(6);
    check("mask_146", int'(lit), 8'h52);
    do_pass(3, 8'h00, -1, -1, -1, -1, 1'b0);
    check("pass1_lit", int'(lit), 0);

    do_pass(-1, 8'h00, -1, -1, -1, -1, 1'b0);

    // Candle 2 never acked: held for the full timeout, then candle 5.
    light(2); light(5);
    do_pass(2, 8'h04, -1, -1, -1, -1, 1'b0);
    check("to_lit", int'(lit), 8'h04);
    check("to_terr", int'(timeout_err), 1);
    do_pass(0, 8'h00, -1, -1, -1, -1, 1'b0);
    check("to_cleared", int'(timeout_err), 0);

    // Relight during a pass: 7 while servicing 0, and 3 on its own ack cycle.
    light(0); light(3);
    do_pass(1, 8'h00, 0, 7, 3, 3, 1'b1);
    check("relight_lit", int'(lit), 0);

    // Extinguish held in IDLE must not touch lit.
    light(3); light(6);
    extinguish = 1'b1;
    repeat (5) tick();
    extinguish = 1'b0;
    check("idle_ext_lit", int'(lit), int'(m_lit));
    check("idle_ext_busy", int'(busy), 0);
    check("idle_ext_en", int'(enable), 0);

    // Ack on the last timeout cycle is a success.
    do_pass(TIMEOUT - 1, 8'h00, -1, -1, -1, -1, 1'b0);
    check("late_ack_terr", int'(timeout_err), 0);

    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(0, 5)) light(int'($urandom_range(0, 7)));
      never = 8'($urandom) & 8'($urandom) & 8'($urandom);
      do_pass(-1, never, -1, -1, -1, -1, 1'($urandom));
    end

    // Reset in the middle of a window.
    light(2); light(6);
    snuff_start = 1'b1;
    tick();
    snuff_start = 1'b0;
    seen = 0;
    while (enable !== 1'b1 && seen < 10) begin
      tick();
      seen++;
    end
    check("mid_en_before_rst", int'(enable), 1);
    #2;
    clr_n = 1'b0;
    #1;
    check("mid_rst_en", int'(enable), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_lit", int'(lit), 0);
    m_lit = 8'd0;
    #2;
    clr_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) seen++;
    end
    check("mid_rst_no_done", seen, 0);
    check("mid_rst_idle_en", int'(enable), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
